// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath: word width, ALU op encoding
// and the op-select helper used by the core.
package datapath_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_INC  = 2'd1,
        OP_AND  = 2'd2
    } alu_op_e;

    // Increment outranks AND when both are requested
    function automatic alu_op_e alu_op_sel(input logic inc, input logic and_op);
        alu_op_e op;
        op = OP_PASS;
        if (inc) begin
            op = OP_INC;
        end else if (and_op) begin
            op = OP_AND;
        end
        return op;
    endfunction

endpackage

// File: rtl/datapath_if.sv
// Control, memory-data and register-observation bundle of the datapath.
// The controller is the master; the datapath core is the slave.
interface datapath_if;
    import datapath_pkg::*;

    logic  PCout, Zlowout, MDRout, R2out, R3out;
    logic  MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in;
    logic  IncPC, Read, AND;
    word_t Mdatain;

    word_t BusMuxOut;
    word_t PC_q, IR_q, MAR_q, MDR_q, Y_q, R1_q, R2_q, R3_q;
    word_t Zlow_q, Zhigh_q;

    modport master (
        output PCout, Zlowout, MDRout, R2out, R3out,
        output MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in,
        output IncPC, Read, AND, Mdatain,
        input  BusMuxOut, PC_q, IR_q, MAR_q, MDR_q, Y_q, R1_q, R2_q, R3_q,
        input  Zlow_q, Zhigh_q
    );

    modport slave (
        input  PCout, Zlowout, MDRout, R2out, R3out,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in,
        input  IncPC, Read, AND, Mdatain,
        output BusMuxOut, PC_q, IR_q, MAR_q, MDR_q, Y_q, R1_q, R2_q, R3_q,
        output Zlow_q, Zhigh_q
    );

endinterface

// File: rtl/datapath_core.sv
// Bus multiplexer, ALU and register file of the datapath, driven entirely by
// the external control lines carried on the interface.
module datapath_core
    import datapath_pkg::*;
(
    input  logic      Clock,
    input  logic      Clear,
    datapath_if.slave dp
);

    word_t   w_bus;
    word_t   w_alu_lo;
    word_t   w_mdr_d;
    alu_op_e w_op;

    word_t w_pc_q, w_ir_q, w_mar_q, w_mdr_q, w_y_q;
    word_t w_r1_q, w_r2_q, w_r3_q, w_zlo_q, w_zhi_q;

    // Fixed-priority bus source select; idle bus reads as zero
    always_comb begin
        w_bus = '0;
        if (dp.PCout) begin
            w_bus = w_pc_q;
        end else if (dp.Zlowout) begin
            w_bus = w_zlo_q;
        end else if (dp.MDRout) begin
            w_bus = w_mdr_q;
        end else if (dp.R2out) begin
            w_bus = w_r2_q;
        end else if (dp.R3out) begin
            w_bus = w_r3_q;
        end
    end

    assign w_op = alu_op_sel(dp.IncPC, dp.AND);

    // ALU: A = Y, B = bus; increment wraps and never carries into Zhigh
    always_comb begin
        w_alu_lo = w_bus;
        case (w_op)
            OP_INC:  w_alu_lo = w_bus + WORD_W'(1);
            OP_AND:  w_alu_lo = w_y_q & w_bus;
            default: w_alu_lo = w_bus;
        endcase
    end

    assign w_mdr_d = dp.Read ? dp.Mdatain : w_bus;

    reg32 u_pc  (.Clock(Clock), .Clear(Clear), .enable(dp.PCin),  .d(w_bus),      .q(w_pc_q));
    reg32 u_ir  (.Clock(Clock), .Clear(Clear), .enable(dp.IRin),  .d(w_bus),      .q(w_ir_q));
    reg32 u_mar (.Clock(Clock), .Clear(Clear), .enable(dp.MARin), .d(w_bus),      .q(w_mar_q));
    reg32 u_mdr (.Clock(Clock), .Clear(Clear), .enable(dp.MDRin), .d(w_mdr_d),    .q(w_mdr_q));
    reg32 u_y   (.Clock(Clock), .Clear(Clear), .enable(dp.Yin),   .d(w_bus),      .q(w_y_q));
    reg32 u_r1  (.Clock(Clock), .Clear(Clear), .enable(dp.R1in),  .d(w_bus),      .q(w_r1_q));
    reg32 u_r2  (.Clock(Clock), .Clear(Clear), .enable(dp.R2in),  .d(w_bus),      .q(w_r2_q));
    reg32 u_r3  (.Clock(Clock), .Clear(Clear), .enable(dp.R3in),  .d(w_bus),      .q(w_r3_q));
    reg32 u_zlo (.Clock(Clock), .Clear(Clear), .enable(dp.Zin),   .d(w_alu_lo),   .q(w_zlo_q));
    reg32 u_zhi (.Clock(Clock), .Clear(Clear), .enable(dp.Zin),   .d(WORD_W'(0)), .q(w_zhi_q));

    assign dp.BusMuxOut = w_bus;
    assign dp.PC_q      = w_pc_q;
    assign dp.IR_q      = w_ir_q;
    assign dp.MAR_q     = w_mar_q;
    assign dp.MDR_q     = w_mdr_q;
    assign dp.Y_q       = w_y_q;
    assign dp.R1_q      = w_r1_q;
    assign dp.R2_q      = w_r2_q;
    assign dp.R3_q      = w_r3_q;
    assign dp.Zlow_q    = w_zlo_q;
    assign dp.Zhigh_q   = w_zhi_q;

endmodule

// File: rtl/datapath_reg32.sv
// 32-bit load-enable register with synchronous clear; clear beats enable.
module reg32
    import datapath_pkg::*;
(
    input  logic  Clock,
    input  logic  Clear,
    input  logic  enable,
    input  word_t d,
    output word_t q
);

    word_t r_q;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_q <= '0;
        end else if (enable) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/datapath.sv
// Top of the single-bus datapath: keeps the flat, positionally ordered port
// list and routes it through the interface into the core.
module datapath
    import datapath_pkg::*;
(
    input  logic  PCout,
    input  logic  Zlowout,
    input  logic  MDRout,
    input  logic  R2out,
    input  logic  R3out,
    input  logic  MARin,
    input  logic  Zin,
    input  logic  PCin,
    input  logic  MDRin,
    input  logic  IRin,
    input  logic  Yin,
    input  logic  IncPC,
    input  logic  Read,
    input  logic  AND,
    input  logic  R1in,
    input  logic  R2in,
    input  logic  R3in,
    input  logic  Clock,
    input  word_t Mdatain,
    input  logic  Clear,
    output word_t BusMuxOut,
    output word_t PC_q,
    output word_t IR_q,
    output word_t MAR_q,
    output word_t MDR_q,
    output word_t Y_q,
    output word_t R1_q,
    output word_t R2_q,
    output word_t R3_q,
    output word_t Zlow_q,
    output word_t Zhigh_q
);

    datapath_if u_if ();

    assign u_if.PCout   = PCout;
    assign u_if.Zlowout = Zlowout;
    assign u_if.MDRout  = MDRout;
    assign u_if.R2out   = R2out;
    assign u_if.R3out   = R3out;
    assign u_if.MARin   = MARin;
    assign u_if.Zin     = Zin;
    assign u_if.PCin    = PCin;
    assign u_if.MDRin   = MDRin;
    assign u_if.IRin    = IRin;
    assign u_if.Yin     = Yin;
    assign u_if.IncPC   = IncPC;
    assign u_if.Read    = Read;
    assign u_if.AND     = AND;
    assign u_if.R1in    = R1in;
    assign u_if.R2in    = R2in;
    assign u_if.R3in    = R3in;
    assign u_if.Mdatain = Mdatain;

    datapath_core u_core (
        .Clock (Clock),
        .Clear (Clear),
        .dp    (u_if)
    );

    assign BusMuxOut = u_if.BusMuxOut;
    assign PC_q      = u_if.PC_q;
    assign IR_q      = u_if.IR_q;
    assign MAR_q     = u_if.MAR_q;
    assign MDR_q     = u_if.MDR_q;
    assign Y_q       = u_if.Y_q;
    assign R1_q      = u_if.R1_q;
    assign R2_q      = u_if.R2_q;
    assign R3_q      = u_if.R3_q;
    assign Zlow_q    = u_if.Zlow_q;
    assign Zhigh_q   = u_if.Zhigh_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for the datapath: a directed vector table for the documented sequences
// and corner cases, then random control words checked against a register model.
module tb_datapath;

    logic clk;
    logic clr;
    datapath_if tb_if ();

    datapath dut (
        .PCout     (tb_if.PCout),
        .Zlowout   (tb_if.Zlowout),
        .MDRout    (tb_if.MDRout),
        .R2out     (tb_if.R2out),
        .R3out     (tb_if.R3out),
        .MARin     (tb_if.MARin),
        .Zin       (tb_if.Zin),
        .PCin      (tb_if.PCin),
        .MDRin     (tb_if.MDRin),
        .IRin      (tb_if.IRin),
        .Yin       (tb_if.Yin),
        .IncPC     (tb_if.IncPC),
        .Read      (tb_if.Read),
        .AND       (tb_if.AND),
        .R1in      (tb_if.R1in),
        .R2in      (tb_if.R2in),
        .R3in      (tb_if.R3in),
        .Clock     (clk),
        .Mdatain   (tb_if.Mdatain),
        .Clear     (clr),
        .BusMuxOut (tb_if.BusMuxOut),
        .PC_q      (tb_if.PC_q),
        .IR_q      (tb_if.IR_q),
        .MAR_q     (tb_if.MAR_q),
        .MDR_q     (tb_if.MDR_q),
        .Y_q       (tb_if.Y_q),
        .R1_q      (tb_if.R1_q),
        .R2_q      (tb_if.R2_q),
        .R3_q      (tb_if.R3_q),
        .Zlow_q    (tb_if.Zlow_q),
        .Zhigh_q   (tb_if.Zhigh_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word bits, in the datapath's positional port order
    localparam logic [16:0] PCO  = 17'h00001, ZLO  = 17'h00002, MDRO = 17'h00004;
    localparam logic [16:0] R2O  = 17'h00008, R3O  = 17'h00010, MARI = 17'h00020;
    localparam logic [16:0] ZI   = 17'h00040, PCI  = 17'h00080, MDRI = 17'h00100;
    localparam logic [16:0] IRI  = 17'h00200, YI   = 17'h00400, INC  = 17'h00800;
    localparam logic [16:0] RD   = 17'h01000, ANDO = 17'h02000, R1I  = 17'h04000;
    localparam logic [16:0] R2I  = 17'h08000, R3I  = 17'h10000;

    localparam int K_PC = 0, K_IR = 1, K_MAR = 2, K_MDR = 3, K_Y = 4;
    localparam int K_R1 = 5, K_R2 = 6, K_R3 = 7, K_ZLO = 8, K_ZHI = 9, K_NONE = -1;

    typedef struct {
        logic        clr;
        logic [16:0] ctl;
        logic [31:0] md;
        logic        bchk;
        logic [31:0] bexp;
        int          k1;
        logic [31:0] e1;
        int          k2;
        logic [31:0] e2;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] m [10];
    string       nm [10] = '{"PC", "IR", "MAR", "MDR", "Y", "R1", "R2", "R3", "Zlow", "Zhigh"};
    int          n_checks = 0;
    int          n_err    = 0;

    function automatic void add(logic c, logic [16:0] ctl, logic [31:0] md, logic bchk,
                                logic [31:0] bexp, int k1, logic [31:0] e1, int k2, logic [31:0] e2);
        vec_t v;
        v = '{c, ctl, md, bchk, bexp, k1, e1, k2, e2};
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] dut_reg(int k);
        case (k)
            K_PC:    return tb_if.PC_q;
            K_IR:    return tb_if.IR_q;
            K_MAR:   return tb_if.MAR_q;
            K_MDR:   return tb_if.MDR_q;
            K_Y:     return tb_if.Y_q;
            K_R1:    return tb_if.R1_q;
            K_R2:    return tb_if.R2_q;
            K_R3:    return tb_if.R3_q;
            K_ZLO:   return tb_if.Zlow_q;
            default: return tb_if.Zhigh_q;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: first asserted source in priority order, else zero
    function automatic logic [31:0] model_bus(logic [16:0] ctl);
        int src_bit [5] = '{0, 1, 2, 3, 4};
        int src_reg [5] = '{K_PC, K_ZLO, K_MDR, K_R2, K_R3};
        for (int i = 0; i < 5; i++) begin
            if (ctl[src_bit[i]]) return m[src_reg[i]];
        end
        return 32'h0;
    endfunction

    function automatic void model_edge(logic c, logic [16:0] ctl, logic [31:0] md);
        int          ld_bit [7] = '{5, 7, 9, 10, 14, 15, 16};
        int          ld_reg [7] = '{K_MAR, K_PC, K_IR, K_Y, K_R1, K_R2, K_R3};
        logic [31:0] b, z;
        logic [31:0] n [10];
        b = model_bus(ctl);
        if (ctl[11])      z = b + 32'd1;
        else if (ctl[13]) z = m[K_Y] & b;
        else              z = b;
        n = m;
        if (c) begin
            for (int i = 0; i < 10; i++) n[i] = 32'h0;
        end else begin
            for (int i = 0; i < 7; i++) if (ctl[ld_bit[i]]) n[ld_reg[i]] = b;
            if (ctl[8]) n[K_MDR] = ctl[12] ? md : b;
            if (ctl[6]) begin
                n[K_ZLO] = z;
                n[K_ZHI] = 32'h0;
            end
        end
        m = n;
    endfunction

    task automatic drive(logic c, logic [16:0] ctl, logic [31:0] md);
        clr           = c;
        tb_if.PCout   = ctl[0];
        tb_if.Zlowout = ctl[1];
        tb_if.MDRout  = ctl[2];
        tb_if.R2out   = ctl[3];
        tb_if.R3out   = ctl[4];
        tb_if.MARin   = ctl[5];
        tb_if.Zin     = ctl[6];
        tb_if.PCin    = ctl[7];
        tb_if.MDRin   = ctl[8];
        tb_if.IRin    = ctl[9];
        tb_if.Yin     = ctl[10];
        tb_if.IncPC   = ctl[11];
        tb_if.Read    = ctl[12];
        tb_if.AND     = ctl[13];
        tb_if.R1in    = ctl[14];
        tb_if.R2in    = ctl[15];
        tb_if.R3in    = ctl[16];
        tb_if.Mdatain = md;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) m[i] = 32'h0;
        drive(1'b0, 17'h0, 32'h0);

        add(1, 17'h0,             32'h0,        0, 32'h0,        K_PC,  32'h0,        K_R1,  32'h0);
        add(0, MDRI|RD,           32'h12,       0, 32'h0,        K_MDR, 32'h12,       K_NONE, 32'h0);
        add(0, MDRO|R2I,          32'h0,        1, 32'h12,       K_R2,  32'h12,       K_MDR, 32'h12);
        add(0, MDRI|RD,           32'h14,       0, 32'h0,        K_MDR, 32'h14,       K_NONE, 32'h0);
        add(0, MDRO|R3I,          32'h0,        1, 32'h14,       K_R3,  32'h14,       K_NONE, 32'h0);
        add(0, MDRI|RD,           32'h18,       0, 32'h0,        K_MDR, 32'h18,       K_NONE, 32'h0);
        add(0, MDRO|R1I,          32'h0,        1, 32'h18,       K_R1,  32'h18,       K_R2,  32'h12);
        add(0, PCO|MARI|INC|ZI,   32'h0,        1, 32'h0,        K_MAR, 32'h0,        K_ZLO, 32'h1);
        add(0, ZLO|PCI|RD|MDRI,   32'h28918000, 1, 32'h1,        K_PC,  32'h1,        K_MDR, 32'h28918000);
        add(0, MDRO|IRI,          32'h0,        1, 32'h28918000, K_IR,  32'h28918000, K_ZHI, 32'h0);
        add(0, R2O|YI,            32'h0,        1, 32'h12,       K_Y,   32'h12,       K_R3,  32'h14);
        add(0, R3O|ANDO|ZI,       32'h0,        1, 32'h14,       K_ZLO, 32'h10,       K_ZHI, 32'h0);
        add(0, ZLO|R1I,           32'h0,        1, 32'h10,       K_R1,  32'h10,       K_R2,  32'h12);
        add(0, PCO|R2O|YI,        32'h0,        1, 32'h1,        K_Y,   32'h1,        K_NONE, 32'h0);
        add(0, 17'h0,             32'h0,        1, 32'h0,        K_PC,  32'h1,        K_NONE, 32'h0);
        add(0, PCO|INC|ANDO|ZI,   32'h0,        1, 32'h1,        K_ZLO, 32'h2,        K_ZHI, 32'h0);
        add(0, MDRI|RD,           32'hFFFFFFFF, 0, 32'h0,        K_MDR, 32'hFFFFFFFF, K_NONE, 32'h0);
        add(0, MDRO|PCI,          32'h0,        1, 32'hFFFFFFFF, K_PC,  32'hFFFFFFFF, K_NONE, 32'h0);
        add(0, PCO|INC|ZI,        32'h0,        1, 32'hFFFFFFFF, K_ZLO, 32'h0,        K_ZHI, 32'h0);
        add(0, PCO|PCI|ZLO,       32'h0,        1, 32'hFFFFFFFF, K_PC,  32'hFFFFFFFF, K_NONE, 32'h0);
        add(1, R1I|MDRO,          32'h0,        1, 32'hFFFFFFFF, K_R1,  32'h0,        K_MDR, 32'h0);
        add(0, 17'h0,             32'h0,        1, 32'h0,        K_PC,  32'h0,        K_IR,  32'h0);
        add(0, MDRI|RD,           32'h55,       0, 32'h0,        K_MDR, 32'h55,       K_Y,   32'h0);
        add(0, MDRO|R3I,          32'h0,        1, 32'h55,       K_R3,  32'h55,       K_ZLO, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].clr, vecs[i].ctl, vecs[i].md);
            #1;
            if (vecs[i].bchk) check($sformatf("vec%0d bus", i), tb_if.BusMuxOut, vecs[i].bexp);
            @(posedge clk);
            model_edge(vecs[i].clr, vecs[i].ctl, vecs[i].md);
            #1;
            if (vecs[i].k1 >= 0) check($sformatf("vec%0d %s", i, nm[vecs[i].k1]), dut_reg(vecs[i].k1), vecs[i].e1);
            if (vecs[i].k2 >= 0) check($sformatf("vec%0d %s", i, nm[vecs[i].k2]), dut_reg(vecs[i].k2), vecs[i].e2);
        end

        // Random control words; the model carries on from the directed state
        for (int t = 0; t < 400; t++) begin
            logic        c;
            logic [16:0] ctl;
            logic [31:0] md;
            c   = ($urandom_range(0, 19) == 0);
            ctl = 17'($urandom);
            md  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            @(negedge clk);
            drive(c, ctl, md);
            #1;
            check($sformatf("rnd%0d bus", t), tb_if.BusMuxOut, model_bus(ctl));
            @(posedge clk);
            model_edge(c, ctl, md);
            #1;
            for (int k = 0; k < 10; k++) check($sformatf("rnd%0d %s", t, nm[k]), dut_reg(k), m[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
